// File: rtl/led_button_ctrl_pkg.sv
// Shared constants for the LED button front-end: one-hot command codes,
// light-level limits, controller state encoding and the press arbiter.
// Pure declarations; no logic and no timing of its own.
package led_button_ctrl_pkg;

    // One-hot command codes; same bit map as the raw button bus.
    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_OFF  = 3'b001;
    localparam logic [2:0] CMD_UP   = 3'b010;
    localparam logic [2:0] CMD_DOWN = 3'b100;

    // Light levels reported back by the downstream FSM.
    localparam logic [2:0] LVL_MIN  = 3'd0;
    localparam logic [2:0] LVL_MAX  = 3'd4;

    // Hold/repeat controller states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } ctrl_state_e;

    // Fixed-priority pick among simultaneous press events: OFF > UP > DOWN.
    // Losers are dropped, so the result is always zero or one-hot.
    function automatic logic [2:0] arb_press(input logic [2:0] press);
        logic [2:0] pick;
        pick = CMD_NONE;
        if (press[0]) begin
            pick = CMD_OFF;
        end else if (press[1]) begin
            pick = CMD_UP;
        end else if (press[2]) begin
            pick = CMD_DOWN;
        end
        return pick;
    endfunction

endpackage

// File: rtl/led_button_ctrl_btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser, stability counter, rise pulse.
// Latency: stable level follows raw input after 2 + DEBOUNCE_CYCLES cycles.
// No backpressure; o_rise is a one-cycle registered pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [1:0]       vld_q;
    logic             armed_q;
    logic             armed_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_raw;
            sync_q <= meta_q;
        end
    end

    // A button already held across reset must be seen released before it may
    // generate a press; vld_q marks when sync_q carries real samples again.
    assign armed_d = armed_q | (vld_q[1] & ~sync_q);

    // Track synchroniser fill after reset and latch the armed flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_d;
        end
    end

    // Count consecutive samples that disagree with the stable level; any
    // agreeing sample restarts the count, so bounces never reach terminal.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
            cnt_d    = '0;
            rise_d   = sync_q & armed_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign o_stable = stable_q;
    assign o_rise   = rise_q;

endmodule

// File: rtl/led_button_ctrl.sv
// Button front-end for the LED level FSM: debounce, arbitrate, hold-to-repeat, idle auto-OFF.
// Latency: raw press to o_cmd pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
// No backpressure: o_cmd is a one-cycle one-hot pulse the downstream FSM must absorb.
module led_button_ctrl
    import led_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100,
    parameter int IDLE_TIMEOUT    = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_btn_raw,
    input  logic [2:0] i_level,
    output logic [2:0] o_cmd,
    output logic [2:0] o_btn_stable,
    output logic       o_repeat_act
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [RPT_W-1:0]  RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]  RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD);
    localparam logic [IDLE_W-1:0] IDLE_LD       = IDLE_W'(IDLE_TIMEOUT);
    localparam bit                IDLE_EN       = (IDLE_TIMEOUT > 0);

    logic [2:0]        stable;
    logic [2:0]        rise;
    logic [2:0]        press_cmd;
    logic [2:0]        btn_cmd;
    logic [2:0]        cmd_d;
    logic              dir_held;
    logic              rpt_expire;
    logic              idle_fire;

    ctrl_state_e       state_q;
    logic [2:0]        dir_q;
    logic [RPT_W-1:0]  rpt_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [2:0]        cmd_q;
    logic              rpt_act_q;

    // One conditioner per button: [0]=OFF, [1]=UP, [2]=DOWN.
    for (genvar g = 0; g < 3; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_raw    (i_btn_raw[g]),
            .o_stable (stable[g]),
            .o_rise   (rise[g])
        );
    end

    assign press_cmd  = arb_press(rise);
    assign dir_held   = |(stable & dir_q);
    assign rpt_expire = (rpt_cnt_q == RPT_W'(1));

    // Button-originated command for this cycle, chosen by controller state.
    always_comb begin
        btn_cmd = CMD_NONE;
        case (state_q)
            S_IDLE: begin
                btn_cmd = press_cmd;
            end
            S_HOLD, S_REPEAT: begin
                // OFF preempts the repeat; the opposite direction is ignored.
                if (rise[0]) begin
                    btn_cmd = CMD_OFF;
                end else if (dir_held && rpt_expire) begin
                    btn_cmd = dir_q;
                end
            end
            S_LOCK: begin
                if (rise[0]) begin
                    btn_cmd = CMD_OFF;
                end
            end
            default: begin
                btn_cmd = CMD_NONE;
            end
        endcase
    end

    // Auto-OFF only fires when no button command claims the cycle, and never
    // while the light is already off.
    assign idle_fire = IDLE_EN && (state_q == S_IDLE) && (btn_cmd == CMD_NONE) &&
                       (i_level != LVL_MIN) && (idle_cnt_q == IDLE_W'(1));

    assign cmd_d = (btn_cmd != CMD_NONE) ? btn_cmd :
                   (idle_fire ? CMD_OFF : CMD_NONE);

    // Hold/repeat controller with registered command and repeat-active outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            dir_q     <= CMD_NONE;
            rpt_cnt_q <= '0;
            cmd_q     <= CMD_NONE;
            rpt_act_q <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            rpt_act_q <= (state_q == S_REPEAT);
            case (state_q)
                S_IDLE: begin
                    if ((press_cmd == CMD_UP) || (press_cmd == CMD_DOWN)) begin
                        dir_q     <= press_cmd;
                        rpt_cnt_q <= RPT_DELAY_LD;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (rise[0]) begin
                        state_q <= S_LOCK;
                    end else if (!dir_held) begin
                        state_q <= S_IDLE;
                    end else if (rpt_expire) begin
                        rpt_cnt_q <= RPT_PERIOD_LD;
                        state_q   <= S_REPEAT;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q - RPT_W'(1);
                    end
                end
                S_LOCK: begin
                    // Stay silent until every button is let go.
                    if (stable == 3'b000) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Inactivity timer: reload on any command or when the light is off,
    // otherwise count down in S_IDLE and park at zero until reloaded.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idle_cnt_q <= '0;
        end else if ((cmd_d != CMD_NONE) || (i_level == LVL_MIN)) begin
            idle_cnt_q <= IDLE_LD;
        end else if ((state_q == S_IDLE) && (idle_cnt_q != '0)) begin
            idle_cnt_q <= idle_cnt_q - IDLE_W'(1);
        end
    end

    assign o_cmd        = cmd_q;
    assign o_btn_stable = stable;
    assign o_repeat_act = rpt_act_q;

endmodule

// File: tb/tb_led_button_ctrl.sv
// Self-checking bench for led_button_ctrl: directed scenarios then random
// button/level traffic, all compared each cycle against an event-level model.
module tb_led_button_ctrl;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int IT = 20;

    logic       clk;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] lvl;
    logic [2:0] o_cmd;
    logic [2:0] o_btn_stable;
    logic       o_repeat_act;

    led_button_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .IDLE_TIMEOUT    (IT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_btn_raw    (btn_raw),
        .i_level      (lvl),
        .o_cmd        (o_cmd),
        .o_btn_stable (o_btn_stable),
        .o_repeat_act (o_repeat_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (edge index k counts clock edges since reset release).
    logic [2:0] hist[$];
    logic [2:0] m_stab, m_press, m_armed;
    bit         m_hold, m_lock, m_idle_on, m_rep_phase;
    int         m_dir, m_t0, m_idle_el;
    logic [2:0] e_cmd, e_stab;
    logic       e_rep;

    // Observation tallies for the directed scenarios.
    int cnt_cmd[3];
    int rep_cyc, cyc, first_up;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_stab = 3'b000; m_press = 3'b000; m_armed = 3'b000;
        m_hold = 0; m_lock = 0; m_idle_on = 0; m_rep_phase = 0;
        m_dir = 0; m_t0 = 0; m_idle_el = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_step();
        logic [2:0] stab_pre, press_pre, ecmd;
        bit was_idle, all_diff;
        int k, d;
        stab_pre  = m_stab;
        press_pre = m_press;
        hist.push_back(btn_raw);
        k = hist.size() - 1;
        was_idle = !m_hold && !m_lock;
        ecmd  = 3'b000;
        e_rep = m_rep_phase;

        if (m_lock) begin
            if (press_pre[0]) ecmd = 3'b001;
            if (stab_pre == 3'b000) m_lock = 0;
        end else if (m_hold) begin
            if (press_pre[0]) begin
                ecmd = 3'b001; m_hold = 0; m_lock = 1;
            end else if (!stab_pre[m_dir]) begin
                m_hold = 0;
            end else begin
                // First repeat RD edges after the initial pulse, then every RP.
                d = k - m_t0;
                if (d == RD || (d > RD && ((d - RD) % RP) == 0))
                    ecmd = (m_dir == 1) ? 3'b010 : 3'b100;
            end
        end else begin
            if (press_pre[0]) ecmd = 3'b001;
            else if (press_pre[1]) begin ecmd = 3'b010; m_hold = 1; m_dir = 1; m_t0 = k; end
            else if (press_pre[2]) begin ecmd = 3'b100; m_hold = 1; m_dir = 2; m_t0 = k; end
        end

        // Idle auto-OFF: IT idle edges since the last command / level-0 edge.
        if (ecmd != 3'b000 || lvl == 3'd0) begin
            m_idle_el = 0; m_idle_on = 1;
        end else if (was_idle && m_idle_on) begin
            if (m_idle_el + 1 == IT) begin ecmd = 3'b001; m_idle_el = 0; end
            else m_idle_el++;
        end
        m_rep_phase = m_hold && ((k - m_t0) >= RD);
        e_cmd = ecmd;

        // Debounce: raw value presented at edge j is seen as a sample at edge j+2;
        // the stable level flips once the last D samples all disagree with it.
        m_press = 3'b000;
        for (int b = 0; b < 3; b++) begin
            all_diff = (k - D + 1 >= 2);
            if (all_diff)
                for (int j = k - D + 1; j <= k; j++)
                    if (hist[j-2][b] == m_stab[b]) all_diff = 0;
            if (all_diff) begin
                m_stab[b] = ~m_stab[b];
                if (m_stab[b] && m_armed[b]) m_press[b] = 1'b1;
            end
            if (k >= 2 && hist[k-2][b] == 1'b0) m_armed[b] = 1'b1;
        end
        e_stab = m_stab;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("cmd", {29'd0, o_cmd}, {29'd0, e_cmd});
        check("stable", {29'd0, o_btn_stable}, {29'd0, e_stab});
        check("repeat_act", {31'd0, o_repeat_act}, {31'd0, e_rep});
        for (int b = 0; b < 3; b++) cnt_cmd[b] += int'(o_cmd[b]);
        if (o_repeat_act) rep_cyc++;
        if (o_cmd == 3'b010 && first_up < 0) first_up = cyc;
    endtask

    task automatic hold(input logic [2:0] r, input int n);
        btn_raw = r;
        repeat (n) step();
    endtask

    task automatic clear_counts();
        for (int b = 0; b < 3; b++) cnt_cmd[b] = 0;
        rep_cyc = 0; cyc = 0; first_up = -1;
    endtask

    // Asynchronous reset applied off-edge; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_cmd", {29'd0, o_cmd}, 32'd0);
        check("rst_stable", {29'd0, o_btn_stable}, 32'd0);
        check("rst_repeat_act", {31'd0, o_repeat_act}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int len;
        logic [2:0] pat;
        bit bounce;
        rst = 1'b0; btn_raw = 3'b000; lvl = 3'd0;
        clear_counts();
        #2;
        do_reset();

        // Clean UP press: one pulse, 2 + D + 1 edges after the first sampling edge.
        hold(3'b000, 5);
        clear_counts();
        hold(3'b010, 8);
        hold(3'b000, 10);
        check("t1_up_count", cnt_cmd[1], 32'd1);
        check("t1_latency", first_up, 32'd7);

        // Bouncing UP never settles: no command at all.
        clear_counts();
        for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 3'b010 : 3'b000, 2);
        hold(3'b000, 10);
        check("t2_cmds", cnt_cmd[0] + cnt_cmd[1] + cnt_cmd[2], 32'd0);

        // UP held 30 cycles: pulse at 7, then +10, then every 3 until release.
        clear_counts();
        hold(3'b010, 30);
        hold(3'b000, 15);
        check("t3_up_count", cnt_cmd[1], 32'd8);
        check("t3_repeat_cycles", rep_cyc, 32'd20);
        check("t3_first_up", first_up, 32'd7);

        // OFF and UP together: OFF wins, UP dropped.
        clear_counts();
        hold(3'b011, 8);
        hold(3'b000, 10);
        check("t4_off", cnt_cmd[0], 32'd1);
        check("t4_up", cnt_cmd[1], 32'd0);

        // DOWN held, OFF pressed mid-hold: OFF pulse, then silence until release.
        clear_counts();
        hold(3'b100, 8);
        hold(3'b101, 6);
        hold(3'b100, 20);
        hold(3'b000, 12);
        check("t5_down", cnt_cmd[2], 32'd1);
        check("t5_off", cnt_cmd[0], 32'd1);

        // Idle auto-OFF at level 3, none at level 0.
        clear_counts();
        hold(3'b000, 3);
        lvl = 3'd3;
        hold(3'b000, 25);
        check("t6_idle_off", cnt_cmd[0], 32'd1);
        clear_counts();
        lvl = 3'd0;
        hold(3'b000, 30);
        check("t6_level0_off", cnt_cmd[0], 32'd0);

        // Reset during repeat; a held button stays silent until re-pressed.
        clear_counts();
        hold(3'b010, 25);
        check("t7_in_repeat", {31'd0, o_repeat_act}, 32'd1);
        do_reset();
        clear_counts();
        hold(3'b010, 30);
        check("t7_held_after_reset", cnt_cmd[1], 32'd0);
        hold(3'b000, 10);
        hold(3'b010, 10);
        check("t7_repress", cnt_cmd[1], 32'd1);
        hold(3'b000, 10);

        // Random traffic: button patterns, bounces, level changes, rare resets.
        for (int seg = 0; seg < 150; seg++) begin
            len = $urandom_range(1, 30);
            pat = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) pat = 3'b000;
            bounce = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) lvl = 3'($urandom_range(0, 4));
            for (int c = 0; c < len; c++) begin
                btn_raw = (bounce && (c % 2 == 1)) ? (pat ^ 3'($urandom_range(0, 7))) : pat;
                step();
            end
            if ($urandom_range(0, 50) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
